if_id_pipe_reg: RTL and testbench



---
 rtl/if_id_pipe_reg_pkg.sv | 39 +++
 rtl/if_id_pipe_reg_sat_counter.sv | 29 ++
 rtl/if_id_pipe_reg.sv | 165 ++++++++++++++++
 tb/tb_if_id_pipe_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// Shared definitions for the ThinPad pipeline boundary registers (if_id, id_ex, ex_mem).
// Holds the default bubble/watch encodings and the per-cycle stage action.
package if_id_pipe_reg_pkg;

    localparam logic [15:0] NOP_INSTR_DEF   = 16'h0800;
    localparam logic [15:0] WATCH_INSTR_DEF = 16'h4F02;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } pipe_act_e;

    // Resolve stall/flush into exactly one action; flush_wins selects which request dominates.
    function automatic pipe_act_e sel_action(input logic stall,
                                             input logic flush,
                                             input logic flush_wins);
        pipe_act_e act;
        if (flush_wins) begin
            if (flush) begin
                act = ACT_FLUSH;
            end else if (stall) begin
                act = ACT_HOLD;
            end else begin
                act = ACT_LOAD;
            end
        end else begin
            if (stall) begin
                act = ACT_HOLD;
            end else if (flush) begin
                act = ACT_FLUSH;
            end else begin
                act = ACT_LOAD;
            end
        end
        return act;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Saturating up-counter used for the pipeline-stage performance counters.
// Sticks at all-ones instead of wrapping.
module if_id_pipe_reg_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] r_cnt;

    // Count requested events, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt <= {W{1'b0}};
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline boundary register with valid bit, stall/flush arbitration,
// optional one-entry skid buffer, saturating counters and debug taps.
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int unsigned           ADDR_W      = 16,
    parameter int unsigned           INSTR_W     = 16,
    parameter logic [INSTR_W-1:0]    NOP_INSTR   = NOP_INSTR_DEF,
    parameter int unsigned           PC_INC      = 1,
    parameter logic [INSTR_W-1:0]    WATCH_INSTR = WATCH_INSTR_DEF,
    parameter int unsigned           CNT_W       = 8,
    parameter int unsigned           FLUSH_WINS  = 0,
    parameter int unsigned           SKID_EN     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               skid_full,
    output logic               skid_ovf,
    output logic [CNT_W-1:0]   watch_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [7:0]         dbg_a,
    output logic [7:0]         dbg_b
);

    localparam logic [ADDR_W-1:0] PC_INC_W = ADDR_W'(PC_INC);
    localparam logic              SKID_ON  = (SKID_EN != 32'd0);
    localparam logic              FW_ON    = (FLUSH_WINS != 32'd0);

    logic               r_valid;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_skid_full;
    logic [ADDR_W-1:0]  r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic               r_ovf;

    pipe_act_e          w_act;
    logic               w_nxt_valid;
    logic [ADDR_W-1:0]  w_nxt_pc;
    logic [INSTR_W-1:0] w_nxt_instr;
    logic               w_nxt_skid_full;
    logic [ADDR_W-1:0]  w_nxt_skid_pc;
    logic [INSTR_W-1:0] w_nxt_skid_instr;
    logic               w_nxt_ovf;
    logic               w_watch_inc;
    logic               w_stall_inc;

    assign w_act = sel_action(stall, flush, FW_ON);

    // Next-state selection for the stage and skid according to the cycle action.
    always_comb begin
        w_nxt_valid      = r_valid;
        w_nxt_pc         = r_pc;
        w_nxt_instr      = r_instr;
        w_nxt_skid_full  = r_skid_full;
        w_nxt_skid_pc    = r_skid_pc;
        w_nxt_skid_instr = r_skid_instr;
        w_nxt_ovf        = r_ovf;
        w_watch_inc      = 1'b0;
        w_stall_inc      = 1'b0;
        case (w_act)
            ACT_FLUSH: begin
                // Skid contents are wrong-path once a redirect happens.
                w_nxt_valid     = 1'b0;
                w_nxt_pc        = {ADDR_W{1'b0}};
                w_nxt_instr     = NOP_INSTR;
                w_nxt_skid_full = 1'b0;
            end
            ACT_HOLD: begin
                w_stall_inc = 1'b1;
                if (in_valid) begin
                    if (SKID_ON && !r_skid_full) begin
                        w_nxt_skid_full  = 1'b1;
                        w_nxt_skid_pc    = in_pc;
                        w_nxt_skid_instr = in_instr;
                    end else begin
                        w_nxt_ovf = 1'b1;
                    end
                end else begin
                    w_nxt_ovf = r_ovf;
                end
            end
            ACT_LOAD: begin
                if (r_skid_full) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_pc    = r_skid_pc + PC_INC_W;
                    w_nxt_instr = r_skid_instr;
                    if (in_valid) begin
                        w_nxt_skid_pc    = in_pc;
                        w_nxt_skid_instr = in_instr;
                    end else begin
                        w_nxt_skid_full = 1'b0;
                    end
                end else if (in_valid) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_pc    = in_pc + PC_INC_W;
                    w_nxt_instr = in_instr;
                end else begin
                    w_nxt_valid = 1'b0;
                    w_nxt_pc    = {ADDR_W{1'b0}};
                    w_nxt_instr = NOP_INSTR;
                end
                w_watch_inc = w_nxt_valid && (w_nxt_instr == WATCH_INSTR);
            end
            default: begin
                w_nxt_valid     = 1'b0;
                w_nxt_pc        = {ADDR_W{1'b0}};
                w_nxt_instr     = NOP_INSTR;
                w_nxt_skid_full = 1'b0;
            end
        endcase
    end

    // Stage and skid state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= {ADDR_W{1'b0}};
            r_instr      <= NOP_INSTR;
            r_skid_full  <= 1'b0;
            r_skid_pc    <= {ADDR_W{1'b0}};
            r_skid_instr <= {INSTR_W{1'b0}};
            r_ovf        <= 1'b0;
        end else begin
            r_valid      <= w_nxt_valid;
            r_pc         <= w_nxt_pc;
            r_instr      <= w_nxt_instr;
            r_skid_full  <= w_nxt_skid_full;
            r_skid_pc    <= w_nxt_skid_pc;
            r_skid_instr <= w_nxt_skid_instr;
            r_ovf        <= w_nxt_ovf;
        end
    end

    if_id_pipe_reg_sat_counter #(.W(CNT_W)) u_watch_cnt (
        .clk   (clk),
        .i_rst (rst),
        .i_inc (w_watch_inc),
        .o_cnt (watch_cnt)
    );

    if_id_pipe_reg_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .i_rst (rst),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign out_instr = r_instr;
    assign skid_full = r_skid_full;
    assign skid_ovf  = r_ovf;
    assign dbg_a     = r_instr[INSTR_W-1 -: 8];
    assign dbg_b     = r_pc[7:0];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench: three parameter variants driven in lockstep and compared
// against a cycle-level behavioural model of the stage rules.
module tb_if_id_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [15:0] in_pc, in_instr;

    logic [2:0]       ob_valid, ob_skid, ob_ovf;
    logic [2:0][15:0] ob_pc, ob_instr;
    logic [2:0][7:0]  ob_dbga, ob_dbgb;
    logic [7:0] wc0, sc0;
    logic [1:0] wc1, sc1;
    logic [3:0] wc2, sc2;

    int total = 0;
    int bad   = 0;

    // variant 0: defaults; 1: flush wins, CNT_W=2, PC_INC=2; 2: no skid, CNT_W=4
    int cfg_fw   [3] = '{0, 1, 0};
    int cfg_skid [3] = '{1, 1, 0};
    int cfg_inc  [3] = '{1, 2, 1};
    int cfg_max  [3] = '{255, 3, 15};

    bit m_valid [3];
    int m_pc    [3];
    int m_instr [3];
    int m_sk_cnt[3];
    int m_sk_pc [3];
    int m_sk_in [3];
    bit m_ovf   [3];
    int m_watch [3];
    int m_stall [3];

    always #5 clk = ~clk;

    if_id_pipe_reg u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(ob_valid[0]), .out_pc(ob_pc[0]),
        .out_instr(ob_instr[0]), .skid_full(ob_skid[0]), .skid_ovf(ob_ovf[0]),
        .watch_cnt(wc0), .stall_cnt(sc0), .dbg_a(ob_dbga[0]), .dbg_b(ob_dbgb[0])
    );

    if_id_pipe_reg #(.FLUSH_WINS(1), .CNT_W(2), .PC_INC(2)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(ob_valid[1]), .out_pc(ob_pc[1]),
        .out_instr(ob_instr[1]), .skid_full(ob_skid[1]), .skid_ovf(ob_ovf[1]),
        .watch_cnt(wc1), .stall_cnt(sc1), .dbg_a(ob_dbga[1]), .dbg_b(ob_dbgb[1])
    );

    if_id_pipe_reg #(.SKID_EN(0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(ob_valid[2]), .out_pc(ob_pc[2]),
        .out_instr(ob_instr[2]), .skid_full(ob_skid[2]), .skid_ovf(ob_ovf[2]),
        .watch_cnt(wc2), .stall_cnt(sc2), .dbg_a(ob_dbga[2]), .dbg_b(ob_dbgb[2])
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bump(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic set_bubble(input int k);
        m_valid[k] = 1'b0;
        m_pc[k]    = 0;
        m_instr[k] = 'h0800;
    endtask

    task automatic set_out(input int k, input int pc, input int ins);
        m_valid[k] = 1'b1;
        m_pc[k]    = (pc + cfg_inc[k]) % 65536;
        m_instr[k] = ins;
        if (ins == 'h4F02) m_watch[k] = bump(m_watch[k], cfg_max[k]);
    endtask

    // Apply one clock edge of the stage rules to each variant's model.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                set_bubble(k);
                m_sk_cnt[k] = 0;
                m_ovf[k]    = 1'b0;
                m_watch[k]  = 0;
                m_stall[k]  = 0;
            end else if (flush && (cfg_fw[k] != 0 || !stall)) begin
                set_bubble(k);
                m_sk_cnt[k] = 0;
            end else if (stall) begin
                m_stall[k] = bump(m_stall[k], cfg_max[k]);
                if (in_valid) begin
                    if (cfg_skid[k] != 0 && m_sk_cnt[k] == 0) begin
                        m_sk_cnt[k] = 1;
                        m_sk_pc[k]  = in_pc;
                        m_sk_in[k]  = in_instr;
                    end else begin
                        m_ovf[k] = 1'b1;
                    end
                end
            end else if (m_sk_cnt[k] > 0) begin
                set_out(k, m_sk_pc[k], m_sk_in[k]);
                if (in_valid) begin
                    m_sk_pc[k] = in_pc;
                    m_sk_in[k] = in_instr;
                end else begin
                    m_sk_cnt[k] = 0;
                end
            end else if (in_valid) begin
                set_out(k, in_pc, in_instr);
            end else begin
                set_bubble(k);
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] wc [3];
        logic [31:0] sc [3];
        wc[0] = 32'(wc0); wc[1] = 32'(wc1); wc[2] = 32'(wc2);
        sc[0] = 32'(sc0); sc[1] = 32'(sc1); sc[2] = 32'(sc2);
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("valid%0d", k), 32'(ob_valid[k]), 32'(m_valid[k]));
            check_val($sformatf("pc%0d", k), 32'(ob_pc[k]), m_pc[k]);
            check_val($sformatf("instr%0d", k), 32'(ob_instr[k]), m_instr[k]);
            check_val($sformatf("skid_full%0d", k), 32'(ob_skid[k]), 32'(m_sk_cnt[k] != 0));
            check_val($sformatf("skid_ovf%0d", k), 32'(ob_ovf[k]), 32'(m_ovf[k]));
            check_val($sformatf("watch%0d", k), wc[k], m_watch[k]);
            check_val($sformatf("stall_cnt%0d", k), sc[k], m_stall[k]);
            check_val($sformatf("dbg_a%0d", k), 32'(ob_dbga[k]), (m_instr[k] >> 8) & 'hFF);
            check_val($sformatf("dbg_b%0d", k), 32'(ob_dbgb[k]), m_pc[k] & 'hFF);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic [15:0] pc, input logic [15:0] ins);
        rst = r; stall = s; flush = f; in_valid = v; in_pc = pc; in_instr = ins;
        cycle();
    endtask

    initial begin
        logic [15:0] stream_ins [3];
        stream_ins[0] = 16'h4F02; stream_ins[1] = 16'h6801; stream_ins[2] = 16'h4F02;

        // reset for two cycles
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_val("reset_instr", 32'(ob_instr[0]), 32'h0800);

        // streaming
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010 + 16'(i), stream_ins[i]);
        check_val("stream_watch", 32'(wc0), 32'd2);
        check_val("stream_pc", 32'(ob_pc[0]), 32'h0013);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // skid capture then overflow
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 16'hAAAA);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0021, 16'hBBBB);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0022, 16'hBBBB);
        check_val("hold_stall_cnt", 32'(sc0), 32'd3);
        check_val("hold_ovf", 32'(ob_ovf[0]), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h1234);
        check_val("release_instr", 32'(ob_instr[0]), 32'hAAAA);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0031, 16'h1235);
        check_val("release_next", 32'(ob_instr[0]), 32'h1234);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // simultaneous stall and flush with the skid occupied
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 16'h5555);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0041, 16'h6666);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0042, 16'h7777);
        check_val("sf_hold_instr", 32'(ob_instr[0]), 32'h5555);
        check_val("sf_flush_instr", 32'(ob_instr[1]), 32'h0800);
        check_val("sf_flush_skid", 32'(ob_skid[1]), 32'd0);

        // PC wrap and bubble
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h1111);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h1111);
        check_val("wrap_pc", 32'(ob_pc[0]), 32'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h2222);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h2222);
        check_val("bubble_instr", 32'(ob_instr[0]), 32'h0800);

        // saturation on the CNT_W=2 variant
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_val("sat_stall_cnt", 32'(sc1), 32'd3);

        // reset with the skid full
        drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0060, 16'h4F02);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_val("rst_skid", 32'(ob_skid[0]), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_val("rst_no_stale", 32'(ob_valid[0]), 32'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [15:0] ins;
            ins = ($urandom_range(0, 3) == 0) ? 16'h4F02 : 16'($urandom);
            drive(1'($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 3) != 0),
                  16'($urandom), ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
